addsub_acc_ctrl: RTL and testbench
==================================

# addsub_acc_ctrl

Sequential command front-end and result register for the 4-bit adder/subtractor. It accepts LOAD/ADD/SUB/CLR commands over a valid/ready handshake and drives the adder/subtractor operands and mode bit. It captures the sum, carry-out and overflow back into a 4-bit accumulator, then presents the registered result downstream over a second valid/ready handshake.

## Interface
Parameters: none (datapath fixed at 4 bits to match the adder/subtractor).

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR
- cmd_data  in  4  operand (ignored for CLR)
- au_a  out  4  adder/subtractor input A = accumulator register
- au_b  out  4  adder/subtractor input B = latched operand register
- au_m  out  1  mode bit: 1 only in EXEC with a latched SUB, otherwise 0
- au_s  in  4  sum/difference from adder/subtractor
- au_co  in  1  carry-out from adder/subtractor
- au_v  in  1  overflow from adder/subtractor
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  4  accumulator value
- res_co  out  1  carry of the last operation
- res_v  out  1  overflow of the last operation
- ovf_sticky  out  1  set by any overflow; cleared only by CLR or rst

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. When cmd_valid=1 at an edge, latch cmd_op into op_r and cmd_data into opnd_r, then go to EXEC.
- EXEC: au_a=acc, au_b=opnd_r, au_m=(op_r==SUB). At the edge, update as follows and go to RESP:
  - LOAD: acc←opnd_r, co←0, v←0.
  - ADD/SUB: acc←au_s, co←au_co, v←au_v. If au_v=1, set ovf_sticky.
  - CLR: acc←0, co←0, v←0, ovf_sticky←0.
- RESP: res_valid=1. res_data, res_co and res_v are held stable until res_valid & res_ready at an edge, which returns the FSM to IDLE.
- cmd_valid outside IDLE is ignored; the command is not consumed.
- Arithmetic: unsigned carry is reported as au_co, with no inversion for SUB. Two's-complement overflow is reported as au_v. Results wrap modulo 16 unless ACC_SAT_EN is defined.
- au_a and au_b come straight from registers, so they are always glitch-free. au_m is decoded from the state register and op_r.
- Reset, asynchronous and valid in any state:
  - FSM returns to IDLE.
  - acc, opnd_r, op_r, res_co, res_v and ovf_sticky go to 0.
  - res_valid=0, cmd_ready=1, au_m=0.
  - An operation in flight is discarded.

## Timing
- Command accepted at edge N; EXEC occupies cycle N..N+1.
- Result registered at edge N+1, so res_valid is high from N+1. Latency is 1 cycle from acceptance to res_valid.
- If res_ready=1 during the first RESP cycle, the FSM is back in IDLE after edge N+2.
- Peak throughput is one command per 3 cycles.
- The adder/subtractor path (au_a/au_b/au_m→au_s/au_co/au_v) must settle within one clock period.
- Backpressure: with res_ready=0, RESP holds indefinitely and cmd_ready stays 0.

## Configuration
- ACC_SAT_EN defined: on an ADD/SUB with au_v=1, acc saturates instead of wrapping.
  - au_s[3]=1 (positive overflow): acc←4'b0111.
  - au_s[3]=0 (negative overflow): acc←4'b1000.
  - res_v, res_co and ovf_sticky still report the raw au_v and au_co.
- ACC_SAT_EN undefined: acc←au_s always (wrap-around).

## Test plan
- Reset mid-EXEC: assert rst asynchronously. All outputs reach reset values immediately; cmd_ready=1.
- LOAD 5 then ADD 3 → res_data=4'b1000, res_co=0, res_v=1, ovf_sticky=1. With ACC_SAT_EN, res_data=4'b0111.
- LOAD 3 then SUB 5 → au_m=1 during EXEC only; res_data=4'b1110, res_co=0, res_v=0.
- LOAD 8 then SUB 1 → res_data=4'b0111, res_co=1, res_v=1. With ACC_SAT_EN, res_data=4'b1000.
- LOAD 15 then ADD 1 → res_data=0, res_co=1, res_v=0. A following CLR → res_data=0, ovf_sticky=0.
- Hold res_ready=0 for 5 cycles in RESP while toggling cmd_valid → res_data stable, cmd_ready=0, no command consumed. Release res_ready → IDLE on the next edge, then the pending command is accepted.

Source files
------------

// File: rtl/addsub_acc_ctrl.sv
// addsub_acc_ctrl
// Command front-end and result register for a 4-bit adder/subtractor.
// Accepts LOAD/ADD/SUB/CLR commands over a valid/ready handshake, drives the
// external arithmetic unit from registers, captures sum/carry/overflow into a
// 4-bit accumulator and presents the result over a second valid/ready port.
//
// Optional feature macro: ACC_SAT_EN
//   defined   : ADD/SUB results that overflow saturate to 4'b0111 / 4'b1000
//   undefined : results wrap modulo 16
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// EXEC  | arithmetic unit driven from acc/opnd_r; result captured on exit
// RESP  | result presented on res_*; held until res_ready
module addsub_acc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic       au_m,
  input  logic [3:0] au_s,
  input  logic       au_co,
  input  logic       au_v,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_co,
  output logic       res_v,
  output logic       ovf_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] op_r;
  logic [3:0] opnd_r;
  logic [3:0] acc;
  logic [3:0] arith_acc;
  logic       cmd_take;
  logic       exec_done;

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/mode decode, all from the state register.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    au_m      = 1'b0;
    cmd_take  = 1'b0;
    exec_done = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_take  = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        au_m      = (op_r == OP_SUB);
        exec_done = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Accumulator value for ADD/SUB: raw sum, or clamped on overflow when saturating.
  always_comb begin
    arith_acc = au_s;
`ifdef ACC_SAT_EN
    if (au_v) begin
      // Overflow flips the sign bit, so a set MSB means positive overflow.
      arith_acc = au_s[3] ? 4'b0111 : 4'b1000;
    end
`endif
  end

  // Command capture: opcode and operand are only latched when accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= OP_LOAD;
      opnd_r <= 4'd0;
    end else if (cmd_take) begin
      op_r   <= cmd_op;
      opnd_r <= cmd_data;
    end
  end

  // Result capture at the end of EXEC; held unchanged through RESP and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= 4'd0;
      res_co     <= 1'b0;
      res_v      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (exec_done) begin
      case (op_r)
        OP_LOAD: begin
          acc    <= opnd_r;
          res_co <= 1'b0;
          res_v  <= 1'b0;
        end
        OP_ADD, OP_SUB: begin
          acc    <= arith_acc;
          res_co <= au_co;
          res_v  <= au_v;
          if (au_v) begin
            ovf_sticky <= 1'b1;
          end
        end
        OP_CLR: begin
          acc        <= 4'd0;
          res_co     <= 1'b0;
          res_v      <= 1'b0;
          ovf_sticky <= 1'b0;
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  // Arithmetic operands come straight from registers so they never glitch.
  assign au_a     = acc;
  assign au_b     = opnd_r;
  assign res_data = acc;

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Directed bench for addsub_acc_ctrl with a behavioural 4-bit adder/subtractor
// connected to the au_* port. Expected values are hand-computed per scenario.
module tb_addsub_acc_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] au_a;
  logic [3:0] au_b;
  logic       au_m;
  logic [3:0] au_s;
  logic       au_co;
  logic       au_v;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_co;
  logic       res_v;
  logic       ovf_sticky;

  int vec_count = 0;
  int miscompares = 0;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

`ifdef ACC_SAT_EN
  localparam logic [3:0] EXP_5P3 = 4'b0111;
  localparam logic [3:0] EXP_8M1 = 4'b1000;
`else
  localparam logic [3:0] EXP_5P3 = 4'b1000;
  localparam logic [3:0] EXP_8M1 = 4'b0111;
`endif

  addsub_acc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .au_a       (au_a),
    .au_b       (au_b),
    .au_m       (au_m),
    .au_s       (au_s),
    .au_co      (au_co),
    .au_v       (au_v),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_co     (res_co),
    .res_v      (res_v),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ripple adder/subtractor: B is inverted and carry-in set for SUB.
  logic [3:0] bx;
  logic [4:0] sum5;
  always_comb begin
    bx    = au_b ^ {4{au_m}};
    sum5  = {1'b0, au_a} + {1'b0, bx} + {4'b0000, au_m};
    au_s  = sum5[3:0];
    au_co = sum5[4];
    au_v  = (au_a[3] == bx[3]) && (sum5[3] != au_a[3]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a command from a negedge and hold it until accepted; returns at
  // the negedge inside EXEC with cmd_valid dropped.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] data);
    bit done;
    done = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cmd_ready) done = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL send_cmd timeout: cmd_ready never high (op=%0d)", op);
    end
  endtask

  // Advance from EXEC to the first RESP negedge, bounded.
  task automatic wait_res();
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (res_valid) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      miscompares++;
      $display("FAIL wait_res timeout: res_valid never high");
    end
  endtask

  // Accept the result in one cycle; returns at the following negedge (IDLE).
  task automatic ack_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec_count++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    vec_count++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    vec_count++; if ({res_data, res_co, res_v, ovf_sticky} !== 7'd0) begin miscompares++; $display("FAIL reset_result got=%b_%b_%b_%b exp=0", res_data, res_co, res_v, ovf_sticky); end
    vec_count++; if ({au_a, au_b, au_m} !== 9'd0) begin miscompares++; $display("FAIL reset_au got=%h_%h_%b exp=0", au_a, au_b, au_m); end
  endtask

  task automatic test_add_overflow();
    send_cmd(OP_LOAD, 4'd5); wait_res(); ack_res();
    send_cmd(OP_ADD, 4'd3);
    vec_count++; if ({au_a, au_b, au_m} !== {4'd5, 4'd3, 1'b0}) begin miscompares++; $display("FAIL add_exec_au got=%h_%h_%b exp=5_3_0", au_a, au_b, au_m); end
    wait_res();
    vec_count++; if (res_data !== EXP_5P3) begin miscompares++; $display("FAIL add_ovf_data got=%b exp=%b", res_data, EXP_5P3); end
    vec_count++; if ({res_co, res_v, ovf_sticky} !== 3'b011) begin miscompares++; $display("FAIL add_ovf_flags got=%b%b%b exp=011", res_co, res_v, ovf_sticky); end
    ack_res();
    vec_count++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL add_ack_idle got rdy=%b vld=%b exp rdy=1 vld=0", cmd_ready, res_valid); end
  endtask

  task automatic test_reset_mid_exec();
    send_cmd(OP_SUB, 4'd2);
    vec_count++; if (au_m !== 1'b1) begin miscompares++; $display("FAIL rst_pre_au_m got=%b exp=1", au_m); end
    #2 rst = 1'b1;
    #1;
    vec_count++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || au_m !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ctl got rdy=%b vld=%b m=%b exp 1 0 0", cmd_ready, res_valid, au_m); end
    vec_count++; if ({au_a, au_b, res_data, res_co, res_v, ovf_sticky} !== 15'd0) begin miscompares++; $display("FAIL rst_mid_regs got a=%h b=%h d=%h co=%b v=%b st=%b exp all 0", au_a, au_b, res_data, res_co, res_v, ovf_sticky); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec_count++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_after got rdy=%b vld=%b exp 1 0", cmd_ready, res_valid); end
  endtask

  task automatic test_sub();
    send_cmd(OP_LOAD, 4'd3);
    vec_count++; if (au_m !== 1'b0) begin miscompares++; $display("FAIL load_exec_au_m got=%b exp=0", au_m); end
    wait_res(); ack_res();
    send_cmd(OP_SUB, 4'd5);
    vec_count++; if ({au_a, au_b, au_m} !== {4'd3, 4'd5, 1'b1}) begin miscompares++; $display("FAIL sub_exec_au got=%h_%h_%b exp=3_5_1", au_a, au_b, au_m); end
    wait_res();
    vec_count++; if (au_m !== 1'b0) begin miscompares++; $display("FAIL sub_resp_au_m got=%b exp=0", au_m); end
    vec_count++; if ({res_data, res_co, res_v, ovf_sticky} !== {4'b1110, 3'b000}) begin miscompares++; $display("FAIL sub_result got=%b_%b%b%b exp=1110_000", res_data, res_co, res_v, ovf_sticky); end
    ack_res();
    vec_count++; if (au_m !== 1'b0) begin miscompares++; $display("FAIL sub_idle_au_m got=%b exp=0", au_m); end
  endtask

  task automatic test_sub_overflow();
    send_cmd(OP_LOAD, 4'd8); wait_res(); ack_res();
    send_cmd(OP_SUB, 4'd1); wait_res();
    vec_count++; if (res_data !== EXP_8M1) begin miscompares++; $display("FAIL sub_ovf_data got=%b exp=%b", res_data, EXP_8M1); end
    vec_count++; if ({res_co, res_v, ovf_sticky} !== 3'b111) begin miscompares++; $display("FAIL sub_ovf_flags got=%b%b%b exp=111", res_co, res_v, ovf_sticky); end
    ack_res();
  endtask

  task automatic test_wrap_clr();
    send_cmd(OP_LOAD, 4'd15); wait_res();
    vec_count++; if ({res_data, res_co, res_v, ovf_sticky} !== {4'hF, 3'b001}) begin miscompares++; $display("FAIL load15_result got=%h_%b%b%b exp=f_001", res_data, res_co, res_v, ovf_sticky); end
    ack_res();
    send_cmd(OP_ADD, 4'd1); wait_res();
    vec_count++; if ({res_data, res_co, res_v, ovf_sticky} !== {4'h0, 3'b101}) begin miscompares++; $display("FAIL wrap_result got=%h_%b%b%b exp=0_101", res_data, res_co, res_v, ovf_sticky); end
    ack_res();
    send_cmd(OP_CLR, 4'd7); wait_res();
    vec_count++; if ({res_data, res_co, res_v, ovf_sticky} !== {4'h0, 3'b000}) begin miscompares++; $display("FAIL clr_result got=%h_%b%b%b exp=0_000", res_data, res_co, res_v, ovf_sticky); end
    ack_res();
  endtask

  task automatic test_back_to_back();
    send_cmd(OP_LOAD, 4'd6); wait_res();
    cmd_op = OP_CLR; cmd_data = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = ~cmd_valid;
      @(negedge clk);
      vec_count++; if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_data !== 4'd6 || au_b !== 4'd6) begin miscompares++; $display("FAIL hold_%0d got vld=%b rdy=%b d=%h b=%h exp 1 0 6 6", i, res_valid, cmd_ready, res_data, au_b); end
    end
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_data = 4'd1;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vec_count++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL release_idle got rdy=%b vld=%b exp 1 0", cmd_ready, res_valid); end
    @(negedge clk);
    cmd_valid = 1'b0;
    vec_count++; if (cmd_ready !== 1'b0 || {au_a, au_b} !== {4'd6, 4'd1}) begin miscompares++; $display("FAIL pending_accept got rdy=%b a=%h b=%h exp 0 6 1", cmd_ready, au_a, au_b); end
    wait_res();
    vec_count++; if ({res_data, res_co, res_v} !== {4'd7, 2'b00}) begin miscompares++; $display("FAIL pending_result got=%h_%b%b exp=7_00", res_data, res_co, res_v); end
    ack_res();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_reset_mid_exec();
    test_sub();
    test_sub_overflow();
    test_wrap_clr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
